// File: rtl/lif_spike_encoder.sv
// Multi-step tau=2 LIF stage: integrates each neuron over TIME_STEPS steps and packs spikes into RAM words.
// Latency: beat at edge N -> nibble packed at N+TIME_STEPS -> o_wr_en for the cycle after N+TIME_STEPS+1.
// Backpressure: none; one neuron per cycle is accepted in S_IDLE/S_RUN, and beats in S_FLUSH/S_DONE are dropped.
//
// Ports:
//   s_clk, s_rst     clock and asynchronous active-high reset
//   i_PsumData       TIME_STEPS signed psums, step t at [P_WIDTH*t +: P_WIDTH]
//   i_PsumValid      one neuron per cycle while high
//   i_Psum_Finish    sticky "layer complete" level from upstream
//   o_wr_en          one-cycle spike RAM write strobe
//   o_wr_addr        write address, wraps after OUT_DEPTH words
//   o_wr_data        neuron j at [TIME_STEPS*j +: TIME_STEPS], bit t = spike at step t
//   o_done           sticky, set after the final write
// Build option: LIF_SOFT_RESET_EN selects a soft membrane reset (v = h - VTH) instead of a hard reset (v = 0).
module lif_spike_encoder #(
  parameter int TIME_STEPS = 4,
  parameter int P_WIDTH    = 20,
  parameter int PACK_NUM   = 16,
  parameter int VTH        = 256,
  parameter int ADDR_WIDTH = 12,
  parameter int OUT_DEPTH  = 1536
) (
  input  logic                           s_clk,
  input  logic                           s_rst,
  input  logic [TIME_STEPS*P_WIDTH-1:0]  i_PsumData,
  input  logic                           i_PsumValid,
  input  logic                           i_Psum_Finish,
  output logic                           o_wr_en,
  output logic [ADDR_WIDTH-1:0]          o_wr_addr,
  output logic [TIME_STEPS*PACK_NUM-1:0] o_wr_data,
  output logic                           o_done
);

  localparam int DW  = TIME_STEPS * P_WIDTH;
  localparam int OW  = TIME_STEPS * PACK_NUM;
  localparam int VW  = P_WIDTH + 2;
  localparam int PCW = (PACK_NUM > 1) ? $clog2(PACK_NUM) : 1;

  localparam logic signed [VW-1:0] VTH_S      = VW'(VTH);
  localparam logic [PCW-1:0]       PACK_LAST  = PCW'(PACK_NUM - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(OUT_DEPTH - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Per-stage pipeline state: membrane potential, the full psum word, spikes so far, valid.
  logic signed [VW-1:0]   v_in   [TIME_STEPS];
  logic signed [VW-1:0]   v_d    [TIME_STEPS];
  logic signed [VW-1:0]   v_q    [TIME_STEPS];
  logic [DW-1:0]          x_in   [TIME_STEPS];
  logic [DW-1:0]          x_d    [TIME_STEPS];
  logic [DW-1:0]          x_q    [TIME_STEPS];
  logic [TIME_STEPS-1:0]  spk_in [TIME_STEPS];
  logic [TIME_STEPS-1:0]  spk_d  [TIME_STEPS];
  logic [TIME_STEPS-1:0]  spk_q  [TIME_STEPS];
  logic [TIME_STEPS-1:0]  vld_in, vld_d, vld_q;

  logic [1:0]             state_d, state_q;
  logic [OW-1:0]          pack_d, pack_q;
  logic [PCW-1:0]         pack_cnt_d, pack_cnt_q;
  logic                   full_d, full_q;
  logic                   wr_en_d, wr_en_q;
  logic [ADDR_WIDTH-1:0]  wr_addr_d, wr_addr_q;
  logic [OW-1:0]          wr_data_d, wr_data_q;
  logic                   done_d, done_q;

  logic                   accept;
  logic                   flush_wr;
  logic signed [VW-1:0]   x_ext;
  logic signed [VW-1:0]   h;

  assign accept   = i_PsumValid && ((state_q == S_IDLE) || (state_q == S_RUN));
  assign flush_wr = (state_q == S_FLUSH) && (pack_cnt_q != '0);

  // LIF datapath: stage k applies step k to the potential handed over by stage k-1.
  always_comb begin
    x_ext     = '0;
    h         = '0;
    v_in[0]   = '0;
    x_in[0]   = i_PsumData;
    spk_in[0] = '0;
    vld_in[0] = accept;
    for (int k = 1; k < TIME_STEPS; k++) begin
      v_in[k]   = v_q[k-1];
      x_in[k]   = x_q[k-1];
      spk_in[k] = spk_q[k-1];
      vld_in[k] = vld_q[k-1];
    end
    for (int k = 0; k < TIME_STEPS; k++) begin
      x_ext = {{2{x_in[k][P_WIDTH*k+P_WIDTH-1]}}, x_in[k][P_WIDTH*k +: P_WIDTH]};
      // tau=2 leak: move halfway from v toward the input, arithmetic shift, no saturation.
      h = v_in[k] + ((x_ext - v_in[k]) >>> 1);
      spk_d[k]    = spk_in[k];
      spk_d[k][k] = (h >= VTH_S);
`ifdef LIF_SOFT_RESET_EN
      v_d[k] = spk_d[k][k] ? (h - VTH_S) : h;
`else
      v_d[k] = spk_d[k][k] ? '0 : h;
`endif
      x_d[k]   = x_in[k];
      vld_d[k] = vld_in[k];
    end
  end

  // Packer, output registers and control FSM.
  always_comb begin
    pack_d     = pack_q;
    pack_cnt_d = pack_cnt_q;
    full_d     = 1'b0;
    state_d    = state_q;
    // A completed word is handed to the output register this cycle, so start a fresh one.
    if (full_q || flush_wr) begin
      pack_d = '0;
    end
    if (flush_wr) begin
      pack_cnt_d = '0;
    end
    if (vld_q[TIME_STEPS-1]) begin
      pack_d[TIME_STEPS*pack_cnt_q +: TIME_STEPS] = spk_q[TIME_STEPS-1];
      if (pack_cnt_q == PACK_LAST) begin
        pack_cnt_d = '0;
        full_d     = 1'b1;
      end else begin
        pack_cnt_d = pack_cnt_q + 1'b1;
      end
    end

    wr_en_d   = full_q || flush_wr;
    wr_data_d = wr_en_d ? pack_q : wr_data_q;
    // The address advances in the cycle after a strobe, so it is valid during the strobe itself.
    wr_addr_d = wr_addr_q;
    if (wr_en_q) begin
      wr_addr_d = (wr_addr_q == ADDR_LAST) ? '0 : wr_addr_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (i_PsumValid)        state_d = S_RUN;
        else if (i_Psum_Finish) state_d = S_FLUSH;
      end
      S_RUN: begin
        if (i_Psum_Finish && !i_PsumValid && (vld_q == '0)) state_d = S_FLUSH;
      end
      S_FLUSH: state_d = S_DONE;
      default: state_d = S_DONE;
    endcase

    done_d = done_q || (state_q == S_DONE);
  end

  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      for (int k = 0; k < TIME_STEPS; k++) begin
        v_q[k]   <= '0;
        x_q[k]   <= '0;
        spk_q[k] <= '0;
      end
      vld_q      <= '0;
      state_q    <= S_IDLE;
      pack_q     <= '0;
      pack_cnt_q <= '0;
      full_q     <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      for (int k = 0; k < TIME_STEPS; k++) begin
        v_q[k]   <= v_d[k];
        x_q[k]   <= x_d[k];
        spk_q[k] <= spk_d[k];
      end
      vld_q      <= vld_d;
      state_q    <= state_d;
      pack_q     <= pack_d;
      pack_cnt_q <= pack_cnt_d;
      full_q     <= full_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      done_q     <= done_d;
    end
  end

  assign o_wr_en   = wr_en_q;
  assign o_wr_addr = wr_addr_q;
  assign o_wr_data = wr_data_q;
  assign o_done    = done_q;

endmodule
